// File: rtl/pre_if_if.sv
// pre_if bus bundle: instruction SRAM-like address handshake plus IF handoff.
// master = pre_if (drives request/handoff), slave = SRAM port + IF stage.
interface pre_if_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        if_allowin;
    logic        to_if_valid;
    logic [31:0] to_if_pc;
    logic        to_if_cancel;
    logic        to_if_adel;

    modport master (
        output inst_req, inst_addr,
        output to_if_valid, to_if_pc, to_if_cancel, to_if_adel,
        input  inst_addr_ok, if_allowin
    );

    modport slave (
        input  inst_req, inst_addr,
        input  to_if_valid, to_if_pc, to_if_cancel, to_if_adel,
        output inst_addr_ok, if_allowin
    );
endinterface

// File: rtl/pre_if.sv
// pre_if: fetch-address generator ahead of IF (REQ/HOLD[/ADEL] FSM).
// Ports: clk, reset (async, active-low), exception_like_now(_pc) CP0
// redirect, br_taken/br_target ID redirect, bus (pre_if_if.master).
// Macro PRE_IF_ADEL_CHECK_EN adds the misaligned-fetch ADEL state.
module pre_if #(
    parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
    parameter int unsigned INST_BYTES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            exception_like_now,
    input  logic [31:0]     exception_like_now_pc,
    input  logic            br_taken,
    input  logic [31:0]     br_target,
    pre_if_if.master        bus
);

`ifdef PRE_IF_ADEL_CHECK_EN
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_ADEL = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1
    } state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        inst_req_q, inst_req_d;
    logic        pend_v_q, pend_v_d;
    logic        pend_exc_q, pend_exc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        cancel_q, cancel_d;

    logic        handshake;
    logic        redir_now;
    logic        idle;
    logic        load;
    logic        capture;
    logic        misalign;
    logic        adel_show;
    logic [31:0] npc;
    logic [31:0] tgt;
    logic [31:0] addr;

    assign handshake = (state_q == S_REQ) && inst_req_q && bus.inst_addr_ok;
    assign redir_now = exception_like_now || br_taken;
    // No request in flight: just after reset, or parked in ADEL.
    assign idle      = !(handshake || (state_q == S_HOLD));

    always_comb begin
        npc = fetch_pc_q + 32'(INST_BYTES);
        if (exception_like_now)
            npc = exception_like_now_pc;
        else if (pend_v_q && pend_exc_q)
            npc = pend_pc_q;
        else if (br_taken)
            npc = br_target;
        else if (pend_v_q)
            npc = pend_pc_q;
    end

    // An idle load without any redirect keeps the current PC.
    assign tgt = (idle && !redir_now && !pend_v_q) ? fetch_pc_q : npc;

`ifdef PRE_IF_ADEL_CHECK_EN
    logic adel_done_q, adel_done_d;
    assign misalign  = (tgt[1:0] != 2'b00);
    assign adel_show = (state_q == S_ADEL) && !adel_done_q;
`else
    assign misalign  = 1'b0;
    assign adel_show = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pend_v_d   = pend_v_q;
        pend_exc_d = pend_exc_q;
        pend_pc_d  = pend_pc_q;
        cancel_d   = cancel_q;
        load       = 1'b0;
        capture    = 1'b0;
`ifdef PRE_IF_ADEL_CHECK_EN
        adel_done_d = adel_done_q;
`endif
        unique case (state_q)
            S_REQ: begin
                if (!inst_req_q) begin
                    load = 1'b1;
                end else if (bus.inst_addr_ok) begin
                    if (bus.if_allowin) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_HOLD;
                        capture = 1'b1;
                    end
                end else begin
                    capture = 1'b1;
                end
            end
            S_HOLD: begin
                if (bus.if_allowin)
                    load = 1'b1;
                else
                    capture = 1'b1;
            end
`ifdef PRE_IF_ADEL_CHECK_EN
            S_ADEL: begin
                if (redir_now)
                    load = 1'b1;
                else if (!adel_done_q && bus.if_allowin)
                    adel_done_d = 1'b1;
            end
`endif
            default: state_d = S_REQ;
        endcase

        // Redirect while a PC is in flight: park it, mark that PC stale.
        if (capture) begin
            if (exception_like_now) begin
                pend_v_d   = 1'b1;
                pend_exc_d = 1'b1;
                pend_pc_d  = exception_like_now_pc;
                cancel_d   = 1'b1;
            end else if (br_taken) begin
                cancel_d = 1'b1;
                if (!(pend_v_q && pend_exc_q)) begin
                    pend_v_d   = 1'b1;
                    pend_exc_d = 1'b0;
                    pend_pc_d  = br_target;
                end
            end
        end

        if (load) begin
            fetch_pc_d = tgt;
            pend_v_d   = 1'b0;
            pend_exc_d = 1'b0;
            cancel_d   = 1'b0;
`ifdef PRE_IF_ADEL_CHECK_EN
            adel_done_d = 1'b0;
            state_d     = misalign ? S_ADEL : S_REQ;
`else
            state_d     = S_REQ;
`endif
        end

        inst_req_d = (state_d == S_REQ) && !(load && misalign);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            inst_req_q <= 1'b0;
            pend_v_q   <= 1'b0;
            pend_exc_q <= 1'b0;
            pend_pc_q  <= 32'h0;
            cancel_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inst_req_q <= inst_req_d;
            pend_v_q   <= pend_v_d;
            pend_exc_q <= pend_exc_d;
            pend_pc_q  <= pend_pc_d;
            cancel_q   <= cancel_d;
        end
    end

`ifdef PRE_IF_ADEL_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            adel_done_q <= 1'b0;
        else
            adel_done_q <= adel_done_d;
    end
`endif

    assign addr             = {fetch_pc_q[31:2], 2'b00};
    assign bus.inst_req     = inst_req_q;
    assign bus.inst_addr    = addr;
    assign bus.to_if_valid  = handshake || (state_q == S_HOLD) || adel_show;
    assign bus.to_if_cancel = bus.to_if_valid && (cancel_q || redir_now);
    assign bus.to_if_adel   = adel_show;
`ifdef PRE_IF_ADEL_CHECK_EN
    assign bus.to_if_pc = (state_q == S_ADEL) ? fetch_pc_q : addr;
`else
    assign bus.to_if_pc = addr;
`endif

endmodule
